// File: rtl/rvsteel_gpio_irq.sv
// GPIO controller with atomic clear/set/toggle, 2-flop input sync and
// per-pin edge-detect interrupts with sticky write-1-to-clear status.
module rvsteel_gpio_irq #(
  parameter int unsigned GPIO_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [5:0]            rw_address,
  output logic [31:0]           read_data,
  input  logic                  read_request,
  output logic                  read_response,
  input  logic [31:0]           write_data,
  input  logic [3:0]            write_strobe,
  input  logic                  write_request,
  output logic                  write_response,
  input  logic [GPIO_WIDTH-1:0] gpio_input,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic [GPIO_WIDTH-1:0] gpio_output,
  output logic                  irq
);

  localparam int unsigned W = GPIO_WIDTH;

  localparam logic [3:0] REG_IN      = 4'd0;
  localparam logic [3:0] REG_OE      = 4'd1;
  localparam logic [3:0] REG_OUT     = 4'd2;
  localparam logic [3:0] REG_CLR     = 4'd3;
  localparam logic [3:0] REG_SET     = 4'd4;
  localparam logic [3:0] REG_TGL     = 4'd5;
  localparam logic [3:0] REG_RISE_EN = 4'd6;
  localparam logic [3:0] REG_FALL_EN = 4'd7;
  localparam logic [3:0] REG_STATUS  = 4'd8;

  logic [W-1:0] oe_q, oe_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] rise_en_q, rise_en_d;
  logic [W-1:0] fall_en_q, fall_en_d;
  logic [W-1:0] status_q, status_d;
  logic [W-1:0] sync1_q, sync2_q, prev_q;
  logic [31:0]  read_data_q, read_data_d;
  logic         read_response_q;
  logic         write_response_q;
  logic         irq_q;

  logic [3:0]   reg_idx_c;
  logic         aligned_c;
  logic [31:0]  byte_mask_c;
  logic [W-1:0] wmask_c;
  logic [W-1:0] keep_c;
  logic [W-1:0] w1c_c;
  logic [W-1:0] rise_c;
  logic [W-1:0] fall_c;

  assign reg_idx_c   = rw_address[5:2];
  assign aligned_c   = (rw_address[1:0] == 2'b00);
  assign byte_mask_c = {{8{write_strobe[3]}}, {8{write_strobe[2]}},
                        {8{write_strobe[1]}}, {8{write_strobe[0]}}};
  assign wmask_c     = W'(write_data & byte_mask_c);
  assign keep_c      = W'(~byte_mask_c);

  assign rise_c = sync2_q & ~prev_q & rise_en_q;
  assign fall_c = ~sync2_q & prev_q & fall_en_q;

  // Register writes; a new edge event overrides a same-cycle W1C of that bit
  always_comb begin
    oe_d      = oe_q;
    out_d     = out_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c_c     = '0;
    if (write_request && aligned_c) begin
      case (reg_idx_c)
        REG_OE:      oe_d      = (oe_q & keep_c) | wmask_c;
        REG_OUT:     out_d     = (out_q & keep_c) | wmask_c;
        REG_CLR:     out_d     = out_q & ~wmask_c;
        REG_SET:     out_d     = out_q | wmask_c;
        REG_TGL:     out_d     = out_q ^ wmask_c;
        REG_RISE_EN: rise_en_d = (rise_en_q & keep_c) | wmask_c;
        REG_FALL_EN: fall_en_d = (fall_en_q & keep_c) | wmask_c;
        REG_STATUS:  w1c_c     = wmask_c;
        default:     ;
      endcase
    end
    status_d = (status_q & ~w1c_c) | rise_c | fall_c;
  end

  // Read mux; write-only, unmapped and unaligned addresses return zero
  always_comb begin
    read_data_d = read_data_q;
    if (read_request) begin
      read_data_d = '0;
      if (aligned_c) begin
        case (reg_idx_c)
          REG_IN:      read_data_d = 32'(sync2_q);
          REG_OE:      read_data_d = 32'(oe_q);
          REG_OUT:     read_data_d = 32'(out_q);
          REG_RISE_EN: read_data_d = 32'(rise_en_q);
          REG_FALL_EN: read_data_d = 32'(fall_en_q);
          REG_STATUS:  read_data_d = 32'(status_q);
          default:     read_data_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      oe_q             <= '0;
      out_q            <= '0;
      rise_en_q        <= '0;
      fall_en_q        <= '0;
      status_q         <= '0;
      sync1_q          <= '0;
      sync2_q          <= '0;
      prev_q           <= '0;
      read_data_q      <= '0;
      read_response_q  <= 1'b0;
      write_response_q <= 1'b0;
      irq_q            <= 1'b0;
    end else begin
      oe_q             <= oe_d;
      out_q            <= out_d;
      rise_en_q        <= rise_en_d;
      fall_en_q        <= fall_en_d;
      status_q         <= status_d;
      sync1_q          <= gpio_input;
      sync2_q          <= sync1_q;
      prev_q           <= sync2_q;
      read_data_q      <= read_data_d;
      read_response_q  <= read_request;
      write_response_q <= write_request;
      irq_q            <= |status_d;
    end
  end

  assign read_data      = read_data_q;
  assign read_response  = read_response_q;
  assign write_response = write_response_q;
  assign gpio_oe        = oe_q;
  assign gpio_output    = out_q;
  assign irq            = irq_q;

endmodule

// File: tb/tb_rvsteel_gpio_irq.sv
// Bench for rvsteel_gpio_irq: register-level model checked every cycle
// plus directed scenarios with literal expectations.
module tb_rvsteel_gpio_irq;

  localparam int unsigned W = 16;

  localparam logic [5:0] A_IN     = 6'h00;
  localparam logic [5:0] A_OE     = 6'h04;
  localparam logic [5:0] A_OUT    = 6'h08;
  localparam logic [5:0] A_CLR    = 6'h0C;
  localparam logic [5:0] A_SET    = 6'h10;
  localparam logic [5:0] A_TGL    = 6'h14;
  localparam logic [5:0] A_RISE   = 6'h18;
  localparam logic [5:0] A_FALL   = 6'h1C;
  localparam logic [5:0] A_STATUS = 6'h20;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [5:0]    rw_address = '0;
  logic [31:0]   read_data;
  logic          read_request = 1'b0;
  logic          read_response;
  logic [31:0]   write_data = '0;
  logic [3:0]    write_strobe = '0;
  logic          write_request = 1'b0;
  logic          write_response;
  logic [W-1:0]  gpio_input = '0;
  logic [W-1:0]  gpio_oe;
  logic [W-1:0]  gpio_output;
  logic          irq;

  int total = 0;
  int bad = 0;

  rvsteel_gpio_irq #(.GPIO_WIDTH(W)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .rw_address     (rw_address),
    .read_data      (read_data),
    .read_request   (read_request),
    .read_response  (read_response),
    .write_data     (write_data),
    .write_strobe   (write_strobe),
    .write_request  (write_request),
    .write_response (write_response),
    .gpio_input     (gpio_input),
    .gpio_oe        (gpio_oe),
    .gpio_output    (gpio_output),
    .irq            (irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Register-level model: array of named registers indexed by address slot,
  // plus a three-deep history of pin samples (sync1, sync2, previous).
  logic [31:0] m_reg [0:8];
  logic [31:0] m_hist [0:2];
  logic [31:0] m_rdata = '0;
  logic        m_rresp = 1'b0;
  logic        m_wresp = 1'b0;
  logic        m_irq = 1'b0;
  logic [31:0] pin_mask = 32'((64'd1 << W) - 64'd1);
  logic [31:0] mv_bm, mv_val, mv_ev, mv_w1c;
  int          mv_idx;
  bit          mv_ok;

  initial begin
    for (int i = 0; i <= 8; i++) m_reg[i] = '0;
    for (int i = 0; i < 3; i++) m_hist[i] = '0;
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= 8; i++) m_reg[i] = '0;
      for (int i = 0; i < 3; i++) m_hist[i] = '0;
      m_rdata = '0; m_rresp = 1'b0; m_wresp = 1'b0; m_irq = 1'b0;
    end else begin
      mv_idx = int'(rw_address[5:2]);
      mv_ok  = (rw_address[1:0] == 2'b00) && (mv_idx <= 8);
      m_rresp = read_request;
      m_wresp = write_request;
      if (read_request) begin
        if (!mv_ok || mv_idx inside {3, 4, 5}) m_rdata = '0;
        else if (mv_idx == 0) m_rdata = m_hist[1];
        else m_rdata = m_reg[mv_idx];
      end
      mv_ev = (m_hist[1] & ~m_hist[2] & m_reg[6]) | (~m_hist[1] & m_hist[2] & m_reg[7]);
      mv_w1c = '0;
      for (int b = 0; b < 4; b++) mv_bm[b*8 +: 8] = write_strobe[b] ? 8'hFF : 8'h00;
      mv_val = write_data & mv_bm & pin_mask;
      if (write_request && mv_ok) begin
        case (mv_idx)
          1, 2, 6, 7: m_reg[mv_idx] = (m_reg[mv_idx] & ~mv_bm) | mv_val;
          3: m_reg[2] = m_reg[2] & ~mv_val;
          4: m_reg[2] = m_reg[2] | mv_val;
          5: m_reg[2] = m_reg[2] ^ mv_val;
          8: mv_w1c = mv_val;
          default: ;
        endcase
      end
      m_reg[8] = (m_reg[8] & ~mv_w1c) | mv_ev;
      m_irq = (m_reg[8] != 0);
      m_hist[2] = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = 32'(gpio_input);
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    chk("cyc_out", 32'(gpio_output), m_reg[2]);
    chk("cyc_oe", 32'(gpio_oe), m_reg[1]);
    chk("cyc_irq", 32'(irq), 32'(m_irq));
    chk("cyc_rresp", 32'(read_response), 32'(m_rresp));
    chk("cyc_wresp", 32'(write_response), 32'(m_wresp));
    chk("cyc_rdata", read_data, m_rdata);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    rw_address = a; write_data = d; write_strobe = s; write_request = 1'b1;
    tick();
    write_request = 1'b0;
    chk("wr_resp", 32'(write_response), 32'd1);
  endtask

  task automatic rd(input string nm, input logic [5:0] a, input logic [31:0] exp);
    rw_address = a; read_request = 1'b1;
    tick();
    read_request = 1'b0;
    chk("rd_resp", 32'(read_response), 32'd1);
    chk(nm, read_data, exp);
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_out", 32'(gpio_output), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    tick();

    // Reset mid-operation, checked between clock edges
    wr(A_OUT, 32'hA5, 4'hF);
    wr(A_OE, 32'hFF, 4'hF);
    rd("pre_rst_out", A_OUT, 32'hA5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_out", 32'(gpio_output), 32'h0);
    chk("async_oe", 32'(gpio_oe), 32'h0);
    chk("async_irq", 32'(irq), 32'h0);
    chk("async_rdata", read_data, 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    rd("post_rst_out", A_OUT, 32'h0);

    // Atomic clear/set/toggle
    wr(A_OUT, 32'hF0, 4'hF);
    wr(A_SET, 32'h0F, 4'hF);
    rd("set", A_OUT, 32'hFF);
    wr(A_CLR, 32'h81, 4'hF);
    rd("clr", A_OUT, 32'h7E);
    wr(A_TGL, 32'hFF, 4'hF);
    rd("tgl", A_OUT, 32'h81);
    rd("clr_reads_zero", A_CLR, 32'h0);

    // Byte strobes and bits above the pin count
    wr(A_OUT, 32'h0, 4'hF);
    wr(A_OUT, 32'hFFFF_FFFF, 4'b0001);
    rd("strb_out", A_OUT, 32'h00FF);
    wr(A_SET, 32'hFF00, 4'b0001);
    rd("strb_set", A_OUT, 32'h00FF);
    wr(A_OUT, 32'hFFFF_FFFF, 4'hF);
    rd("upper_bits", A_OUT, 32'h0000_FFFF);

    // Edge detection, W1C and irq
    wr(A_RISE, 32'h01, 4'hF);
    wr(A_FALL, 32'h02, 4'hF);
    gpio_input = 16'h0003;
    tick();
    tick();
    rd("in_latency", A_IN, 32'h3);
    repeat (8) tick();
    gpio_input = 16'h0000;
    repeat (10) tick();
    rd("in_low", A_IN, 32'h0);
    rd("status_both", A_STATUS, 32'h3);
    chk("irq_set", 32'(irq), 32'h1);
    wr(A_STATUS, 32'h01, 4'hF);
    rd("status_w1c0", A_STATUS, 32'h2);
    chk("irq_hold", 32'(irq), 32'h1);
    wr(A_STATUS, 32'h02, 4'hF);
    chk("irq_drop", 32'(irq), 32'h0);
    wr(A_RISE, 32'h00, 4'hF);
    rd("en_clear_keeps", A_STATUS, 32'h0);
    wr(A_RISE, 32'h01, 4'hF);

    // W1C in the same cycle a new rise is detected
    gpio_input = 16'h0001;
    tick();
    tick();
    wr(A_STATUS, 32'h01, 4'hF);
    rd("collision", A_STATUS, 32'h1);
    chk("collision_irq", 32'(irq), 32'h1);
    wr(A_STATUS, 32'h01, 4'hF);
    chk("collision_clr_irq", 32'(irq), 32'h0);

    // Illegal accesses
    wr(A_OE, 32'h3C, 4'hF);
    wr(A_OUT, 32'h81, 4'hF);
    rd("pre_illegal", A_OUT, 32'h81);
    rd("unaligned_rd", 6'h05, 32'h0);
    rd("unmapped_rd", 6'h28, 32'h0);
    wr(6'h06, 32'hFF, 4'hF);
    wr(A_IN, 32'hFF, 4'hF);
    rd("illegal_oe", A_OE, 32'h3C);
    rd("illegal_out", A_OUT, 32'h81);
    rd("illegal_in", A_IN, 32'h1);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rvsteel_gpio_irq.md
Name: rvsteel_gpio_irq

Overview:
Parametrised GPIO controller for RISC-V Steel SoCs with up to 32 pins. It provides per-pin output enable and output data, atomic clear, set and toggle, and 2-flop input synchronisation. It adds per-pin rising/falling edge detection with sticky write-1-to-clear status and a level interrupt output. It sits on the system IO bus as a memory-mapped slave and honours byte strobes.

Parameters:
GPIO_WIDTH, 8, number of pins; legal range 1..32; register bits above GPIO_WIDTH-1 read 0 and ignore writes.

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset_n  input  1  asynchronous active-low reset; assertion clears all state immediately, deassertion is synchronous to clock
rw_address  input  6  byte address of register
read_data  output  32  read return data
read_request  input  1  read strobe, one cycle per access
read_response  output  1  read acknowledge
write_data  input  32  write data
write_strobe  input  4  byte enables for write_data
write_request  input  1  write strobe, one cycle per access
write_response  output  1  write acknowledge
gpio_input  input  GPIO_WIDTH  asynchronous pin inputs
gpio_oe  output  GPIO_WIDTH  per-pin output enable
gpio_output  output  GPIO_WIDTH  per-pin output value
irq  output  1  level interrupt, high while any status bit is set

Behaviour:
- Register map, word-aligned (rw_address[1:0]==0), index = rw_address[5:2]:
  - 0 IN (RO): synchronised inputs.
  - 1 OE (RW).
  - 2 OUT (RW).
  - 3 CLR (WO): OUT &= ~mask.
  - 4 SET (WO): OUT |= mask.
  - 5 TGL (WO): OUT ^= mask.
  - 6 RISE_EN (RW).
  - 7 FALL_EN (RW).
  - 8 STATUS (RW1C).
  - 9..15 unmapped.
- Byte strobes: mask = write_data with each byte zeroed where write_strobe bit = 0. For RW registers, bytes with strobe 0 keep their old value.
- Reset (reset_n low, asynchronous): the following go to 0: OE, OUT, RISE_EN, FALL_EN, STATUS, both sync stages, previous-sample flop, read_data, read_response, write_response, irq.
- Responses: read_response and write_response are asserted exactly 1 cycle after the corresponding request, for every request, including unaligned or unmapped addresses. They are never asserted without a request.
- read_data: updated only on read_request, at the same edge read_response is set.
  - Valid read: zero-extended register value.
  - WO registers, unmapped or unaligned addresses: read returns 0.
  - With no request, read_data holds its last value.
- Writes take effect at the edge following the write_request cycle. Writes are ignored if the address is unaligned or unmapped, or to IN.
- Input path: sync1 <= gpio_input; sync2 <= sync1; prev <= sync2. IN reads sync2.
  - A pin change meeting setup before edge k is visible in sync2 after edge k+1.
- Edge detect:
  - rise = sync2 & ~prev & RISE_EN
  - fall = ~sync2 & prev & FALL_EN
  - STATUS_next = (STATUS & ~w1c_mask) | rise | fall
  - A new event wins over a same-cycle W1C clear of the same bit.
  - Events are ignored while the enable bit is 0, and status is not retroactively set when enable rises. Clearing an enable does not clear STATUS.
- irq: registered, irq <= |STATUS_next. It rises in the same cycle STATUS becomes nonzero and falls in the cycle STATUS becomes zero.
- OUT updates: at most one write per cycle, so CLR/SET/TGL/OUT writes never collide. gpio_output = OUT and gpio_oe = OE directly, with no extra latency.
- Back-to-back requests on consecutive cycles are all serviced; there is no stall.

Test Plan:
- Reset mid-operation: write OUT=0xA5, OE=0xFF, then pulse reset_n low asynchronously between clock edges -> gpio_output, gpio_oe, irq, and read_data become 0 immediately without waiting for a clock edge; a read of OUT after release returns 0.
- Atomic ops (GPIO_WIDTH=8):
  - OUT=0xF0, SET 0x0F -> 0xFF.
  - CLR 0x81 -> 0x7E.
  - TGL 0xFF -> 0x81.
  - Every read_response arrives 1 cycle after its request.
- Strobes: OUT=0x00; write OUT=0xFFFF_FFFF with strobe 4'b0001 at GPIO_WIDTH=16 -> OUT=0x00FF. SET 0xFF00 with strobe 4'b0001 -> OUT unchanged at 0x00FF.
- Edges: RISE_EN=0x01, FALL_EN=0x02; gpio_input goes 0x00 -> 0x03 -> 0x00 with 10-cycle gaps -> STATUS=0x03, irq=1, IN reads 0x03 then 0x00 at 2-cycle latency; write STATUS=0x01 -> STATUS=0x02, irq stays 1; write STATUS=0x02 -> irq drops to 0.
- Collision: W1C of bit0 issued in the same cycle a new rise on pin0 is detected -> STATUS bit0 remains 1.
- Illegal access: read at 0x05 and at 0x28, write 0xFF to 0x06 and to IN -> responses returned, read_data=0, no register changes.
